video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen_pkg.sv | 43 ++++
 rtl/video_timing_core.sv | 116 +++++++++++
 rtl/video_timing_gen.sv | 142 ++++++++++++++
 tb/tb_video_timing_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared video definitions: default 640x480@60 timing, sync polarities,
// coordinate width and the test-pattern encoding used with the serializer.
package video_timing_gen_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_HS_POL   = 0;
    localparam int DEF_VS_POL   = 0;

    localparam int COORD_W      = 12;
    localparam int NUM_BARS     = 8;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_t;

    // Colour-bar palette, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            3'd7:    bar_colour = 24'h000000;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster counters plus registered de/sync/coordinate outputs; the counter
// state is also exported so the pattern logic can stay in lock-step.
module video_timing_core
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = DEF_HS_POL,
    parameter int VS_POL   = DEF_VS_POL
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v,
    output logic               line_end,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] ZERO     = COORD_W'(0);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic               HS_ON    = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic               VS_ON    = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic [COORD_W-1:0] h_r;
    logic [COORD_W-1:0] v_r;
    logic               de_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               frame_start_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;

    logic               active_s;
    logic               hs_act_s;
    logic               vs_act_s;
    logic               first_s;
    logic               line_end_s;

    // Decode the current raster position into region flags.
    always_comb begin
        active_s   = (h_r < H_ACT) && (v_r < V_ACT);
        hs_act_s   = (h_r >= HS_START) && (h_r < HS_END);
        vs_act_s   = (v_r >= VS_START) && (v_r < VS_END);
        first_s    = (h_r == ZERO) && (v_r == ZERO);
        line_end_s = (h_r == H_LAST);
    end

    // Horizontal/vertical raster counters; v only moves at line end.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r <= ZERO;
            v_r <= ZERO;
        end else if (line_end_s) begin
            h_r <= ZERO;
            if (v_r == V_LAST) begin
                v_r <= ZERO;
            end else begin
                v_r <= v_r + ONE;
            end
        end else begin
            h_r <= h_r + ONE;
        end
    end

    // Timing outputs, registered one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_r          <= 1'b0;
            x_r           <= ZERO;
            y_r           <= ZERO;
            frame_start_r <= 1'b0;
            hsync_r       <= ~HS_ON;
            vsync_r       <= ~VS_ON;
        end else begin
            de_r          <= active_s;
            x_r           <= active_s ? h_r : ZERO;
            y_r           <= active_s ? v_r : ZERO;
            frame_start_r <= first_s;
            hsync_r       <= hs_act_s ? HS_ON : ~HS_ON;
            vsync_r       <= vs_act_s ? VS_ON : ~VS_ON;
        end
    end

    assign h           = h_r;
    assign v           = v_r;
    assign line_end    = line_end_s;
    assign de          = de_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = frame_start_r;
    assign x           = x_r;
    assign y           = y_r;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator with built-in test patterns; the timing core owns
// the raster, this level picks and registers the pixel colour.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = DEF_HS_POL,
    parameter int VS_POL   = DEF_VS_POL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pat_sel,
    input  logic [23:0]        solid_rgb,
    output logic [23:0]        rgb,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    localparam logic [COORD_W-1:0] ZERO     = COORD_W'(0);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);

    logic [COORD_W-1:0] h_s;
    logic [COORD_W-1:0] v_s;
    logic               line_end_s;
    logic               active_s;
    logic               first_s;

    pattern_t           pat_r;
    pattern_t           pat_eff_s;
    logic [23:0]        pix_s;
    logic [23:0]        rgb_r;
    logic [COORD_W-1:0] bar_px_r;
    logic [2:0]         bar_idx_r;

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .h           (h_s),
        .v           (v_s),
        .line_end    (line_end_s),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .x           (x),
        .y           (y)
    );

    // Region flags for the pixel path, evaluated on the same counter state.
    always_comb begin
        active_s = (h_s < H_ACT) && (v_s < V_ACT);
        first_s  = (h_s == ZERO) && (v_s == ZERO);
    end

    // At the first pixel of a frame the new selection applies immediately,
    // so the whole frame (pixel 0 included) uses one pattern.
    always_comb begin
        if (first_s) begin
            pat_eff_s = pattern_t'(pat_sel);
        end else begin
            pat_eff_s = pat_r;
        end
    end

    // Frame-locked pattern register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r <= PAT_BARS;
        end else begin
            pat_r <= pat_eff_s;
        end
    end

    // Bar position counter: restarts each line, last bar holds to line end.
    always_ff @(posedge clk) begin
        if (rst || line_end_s) begin
            bar_px_r  <= ZERO;
            bar_idx_r <= 3'd0;
        end else if (bar_px_r == BAR_LAST) begin
            bar_px_r <= ZERO;
            if (bar_idx_r != 3'd7) begin
                bar_idx_r <= bar_idx_r + 3'd1;
            end else begin
                bar_idx_r <= bar_idx_r;
            end
        end else begin
            bar_px_r  <= bar_px_r + ONE;
            bar_idx_r <= bar_idx_r;
        end
    end

    // Pixel colour for the current counter position.
    always_comb begin
        pix_s = 24'h000000;
        case (pat_eff_s)
            PAT_BARS:     pix_s = bar_colour(bar_idx_r);
            PAT_GRADIENT: pix_s = {3{h_s[9:2]}};
            PAT_CHECKER:  pix_s = (h_s[5] ^ v_s[5]) ? 24'h000000 : 24'hFFFFFF;
            PAT_SOLID:    pix_s = solid_rgb;
            default:      pix_s = 24'h000000;
        endcase
    end

    // Registered pixel output, blanked outside the active window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= 24'h000000;
        end else begin
            rgb_r <= active_s ? pix_s : 24'h000000;
        end
    end

    assign rgb = rgb_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: arithmetic raster model checked every cycle,
// plus literal pixel/timing expectations and whole-frame statistics.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 36;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BUDGET   = 2 * H_TOTAL * V_TOTAL;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h000000;
    logic [23:0] rgb;
    logic        de, hsync, vsync, frame_start;
    logic [11:0] x, y;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .frame_start(frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_pixel(input int h, input int v,
                                                input logic [1:0] p, input logic [23:0] s);
        logic [7:0] g;
        case (p)
            2'd0:    return BARS[h / (H_ACTIVE / 8)];
            2'd1:    begin g = 8'((h / 4) % 256); return {g, g, g}; end
            2'd2:    return ((((h / 32) % 2) ^ ((v / 32) % 2)) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    // Model: raster position of the counters, and what the outputs now describe.
    int          mh = 0, mv = 0, mframe = 0;
    logic [1:0]  mpat = 2'd0;
    bit          mvalid = 1'b0;
    bit          o_rst = 1'b1;
    int          oh = 0, ov = 0, oframe = 0;
    logic [1:0]  e_pat = 2'd0;
    logic [23:0] e_solid = 24'h000000;

    always @(posedge clk) begin
        if (rst) begin
            mh = 0; mv = 0; mframe = 0; mpat = 2'd0; o_rst = 1'b1;
        end else begin
            if (mh == 0 && mv == 0) mpat = pat_sel;
            o_rst = 1'b0; oh = mh; ov = mv; oframe = mframe;
            e_pat = mpat; e_solid = solid_rgb;
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0; mv++;
                if (mv == V_TOTAL) begin mv = 0; mframe++; end
            end
        end
        mvalid = 1'b1;
    end

    // Frame statistics (from DUT outputs only) for the first full frame.
    bit st_active = 1'b0, st_done = 1'b0, prev_hs = 1'b1;
    int st_cyc = 0, de_cnt = 0, hs_cnt = 0, hs_len = 0, vs_first = -1, vs_last = -1;

    always @(negedge clk) begin
        logic        ede, ehs, evs, efs;
        logic [11:0] ex, ey;
        logic [23:0] erg;
        if (mvalid) begin
            if (o_rst) begin
                ede = 1'b0; ex = 12'd0; ey = 12'd0; efs = 1'b0;
                ehs = 1'b1; evs = 1'b1; erg = 24'h000000;
            end else begin
                ede = (oh < H_ACTIVE) && (ov < V_ACTIVE);
                ex  = ede ? 12'(oh) : 12'd0;
                ey  = ede ? 12'(ov) : 12'd0;
                efs = (oh == 0) && (ov == 0);
                ehs = !((oh >= H_ACTIVE + H_FP) && (oh < H_ACTIVE + H_FP + H_SYNC));
                evs = !((ov >= V_ACTIVE + V_FP) && (ov < V_ACTIVE + V_FP + V_SYNC));
                erg = ede ? model_pixel(oh, ov, e_pat, e_solid) : 24'h000000;
            end
            chk("model_de", de, ede);
            chk("model_x", x, ex);
            chk("model_y", y, ey);
            chk("model_frame_start", frame_start, efs);
            chk("model_hsync", hsync, ehs);
            chk("model_vsync", vsync, evs);
            chk("model_rgb", rgb, erg);

            if (!o_rst && phase == 1 && oframe == 0 && oh == 80 && ov == 30)
                chk("bars_after_sel_change", rgb, 24'hFFFF00);
            if (!o_rst && phase == 1 && oframe == 1 && ov == 0 && oh == 0)
                chk("chk_0_0", rgb, 24'hFFFFFF);
            if (!o_rst && phase == 1 && oframe == 1 && ov == 0 && oh == 32)
                chk("chk_32_0", rgb, 24'h000000);
            if (!o_rst && phase == 1 && oframe == 1 && ov == 32 && oh == 32)
                chk("chk_32_32", rgb, 24'hFFFFFF);
            if (!o_rst && phase == 3 && ov == 1 && oh == 639) chk("solid_639_1", rgb, 24'h123456);
            if (!o_rst && phase == 3 && ov == 1 && oh == 640) chk("solid_blank", rgb, 24'h000000);
            if (!o_rst && phase == 4 && ov == 0 && oh == 4)   chk("grad_x4", rgb, 24'h010101);
            if (!o_rst && phase == 4 && ov == 0 && oh == 639) chk("grad_x639", rgb, 24'h9F9F9F);
        end

        if (frame_start === 1'b1 && st_active) begin
            chk("frame_cycles", st_cyc, H_TOTAL * V_TOTAL);
            chk("de_cycles", de_cnt, 640 * 36);
            chk("hsync_pulses", hs_cnt, 40);
            chk("vsync_first_line", vs_first, 37);
            chk("vsync_last_line", vs_last, 38);
            st_active = 1'b0; st_done = 1'b1;
        end
        if (frame_start === 1'b1 && phase == 1 && !st_active && !st_done) begin
            st_active = 1'b1; st_cyc = 0; de_cnt = 0; hs_cnt = 0; hs_len = 0;
            vs_first = -1; vs_last = -1; prev_hs = 1'b1;
        end
        if (st_active) begin
            if (st_cyc == 0) begin
                chk("first_frame_start", frame_start, 1'b1);
                chk("first_de", de, 1'b1);
                chk("bar0_x0", rgb, 24'hFFFFFF);
            end
            if (st_cyc == 79)  chk("bar0_x79", rgb, 24'hFFFFFF);
            if (st_cyc == 80)  chk("bar1_x80", rgb, 24'hFFFF00);
            if (st_cyc == 159) chk("bar1_x159", rgb, 24'hFFFF00);
            if (st_cyc == 559) chk("bar6_x559", rgb, 24'h0000FF);
            if (st_cyc == 560) begin chk("bar7_x560", rgb, 24'h000000); chk("de_x560", de, 1'b1); end
            if (st_cyc == 639) begin chk("bar7_x639", rgb, 24'h000000); chk("de_x639", de, 1'b1); end
            if (st_cyc == 640) chk("de_x640", de, 1'b0);
            if (de === 1'b1) de_cnt++;
            if (hsync === 1'b0 && prev_hs) begin
                hs_cnt++; hs_len = 0;
                chk("hsync_start_h", st_cyc % H_TOTAL, 656);
            end
            if (hsync === 1'b0) hs_len++;
            if (hsync === 1'b1 && !prev_hs) chk("hsync_len", hs_len, 96);
            if (vsync === 1'b0) begin
                if (vs_first < 0) vs_first = st_cyc / H_TOTAL;
                vs_last = st_cyc / H_TOTAL;
            end
            prev_hs = (hsync === 1'b1);
            st_cyc++;
        end
    end

    // Wait (at negedge) until the counters sit at (th,tv); bounded.
    task automatic wait_hv(input int th, input int tv);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(mh == th && mv == tv) && n < BUDGET);
        if (!(mh == th && mv == tv)) begin
            n_tests++; n_fail++;
            $display("FAIL wait_hv timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", mh, mv, th, tv);
        end
    endtask

    initial begin
        rst = 1'b1; pat_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_rgb", rgb, 24'h000000);
        chk("rst_frame_start", frame_start, 1'b0);

        phase = 1; rst = 1'b0;
        wait_hv(0, 20);
        pat_sel = 2'd2;
        wait_hv(0, 0);
        wait_hv(0, 34);

        phase = 3; pat_sel = 2'd3; solid_rgb = 24'h123456; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("solid_0_0", rgb, 24'h123456);
        chk("solid_fs", frame_start, 1'b1);
        wait_hv(0, 2);

        phase = 4; pat_sel = 2'd1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_hv(300, 2);

        phase = 5; rst = 1'b1;
        @(negedge clk);
        chk("midrst_de", de, 1'b0);
        chk("midrst_rgb", rgb, 24'h000000);
        chk("midrst_hsync", hsync, 1'b1);
        chk("midrst_fs", frame_start, 1'b0);
        chk("midrst_x", x, 12'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_fs", frame_start, 1'b1);
        chk("postrst_de", de, 1'b1);
        chk("postrst_x", x, 12'd0);
        chk("postrst_y", y, 12'd0);
        @(negedge clk);
        chk("postrst_fs_pulse", frame_start, 1'b0);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
